// File: rtl/dispatch_stage.sv
// dispatch_stage: registered multi-lane dispatch allocating ROB tags, LSQ ids and RS slots.
// Optional DISPATCH_CDB_SNOOP_EN: capture CDB broadcasts into operands at accept and while held.
module dispatch_stage #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ROB_SIZE       = 16,
  parameter int LSQ_SIZE       = 8,
  parameter int RS_SIZE        = 8,
  parameter int NUM_CDB        = 2,
  parameter int XLEN           = 32,
  localparam int W  = DISPATCH_WIDTH,
  localparam int TW = $clog2(ROB_SIZE + 1),
  localparam int LW = $clog2(LSQ_SIZE + 1),
  localparam int SW = $clog2(RS_SIZE),
  localparam int RW = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [W-1:0]            in_valid,
  input  logic [W-1:0]            in_is_mem,
  input  logic [W-1:0]            in_bypass_rs,
  input  logic [W*TW-1:0]         in_tag1,
  input  logic [W*TW-1:0]         in_tag2,
  input  logic [W*XLEN-1:0]       in_val1,
  input  logic [W*XLEN-1:0]       in_val2,
  output logic                    in_ready,
  input  logic [RS_SIZE-1:0]      rs_busy,
  input  logic [RW-1:0]           rob_retire,
  input  logic [RW-1:0]           lsq_retire,
  input  logic [NUM_CDB-1:0]      cdb_valid,
  input  logic [NUM_CDB*TW-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0] cdb_value,
  output logic [W-1:0]            out_valid,
  input  logic                    out_ready,
  output logic [W*TW-1:0]         out_rob_tag,
  output logic [W*LW-1:0]         out_lsq_id,
  output logic [W*SW-1:0]         out_rs_id,
  output logic [W*TW-1:0]         out_tag1,
  output logic [W*TW-1:0]         out_tag2,
  output logic [W*XLEN-1:0]       out_val1,
  output logic [W*XLEN-1:0]       out_val2,
  output logic [TW-1:0]           rob_count,
  output logic [LW-1:0]           lsq_count,
  output logic                    rob_full,
  output logic                    lsq_full
);

  localparam int RIW = $clog2(ROB_SIZE);
  localparam int LIW = $clog2(LSQ_SIZE);

  logic [RIW-1:0]     rob_tail, rob_tail_nx;
  logic [LIW-1:0]     lsq_tail, lsq_tail_nx;
  logic [W-1:0]       out_uses_rs, nx_uses_rs;
  logic [W*TW-1:0]    nx_rob_tag, nx_tag1, nx_tag2;
  logic [W*LW-1:0]    nx_lsq_id;
  logic [W*SW-1:0]    nx_rs_id;
  logic [W*XLEN-1:0]  nx_val1, nx_val2;
  logic [RS_SIZE-1:0] held_rs;
  int                 n_rob, n_lsq, n_rs, free_rs;
  logic               accept;

`ifdef DISPATCH_CDB_SNOOP_EN
  // Lowest-indexed matching broadcast wins; tag 0 is already a value and never matches.
  function automatic logic [TW+XLEN-1:0] cap(input logic [TW-1:0] tag, input logic [XLEN-1:0] val);
    logic [TW+XLEN-1:0] r;
    logic               hit;
    r   = {tag, val};
    hit = 1'b0;
    for (int c = 0; c < NUM_CDB; c++)
      if (!hit && tag != '0 && cdb_valid[c] && cdb_tag[c*TW +: TW] == tag) begin
        r   = {{TW{1'b0}}, cdb_value[c*XLEN +: XLEN]};
        hit = 1'b1;
      end
    return r;
  endfunction
`else
  function automatic logic [TW+XLEN-1:0] cap(input logic [TW-1:0] tag, input logic [XLEN-1:0] val);
    return {tag, val};
  endfunction

  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_tag, cdb_value};
`endif

  // Slots still sitting in the output register are not yet visible in rs_busy.
  always_comb begin
    held_rs = '0;
    for (int i = 0; i < W; i++)
      if (out_valid[i] && out_uses_rs[i]) held_rs[out_rs_id[i*SW +: SW]] = 1'b1;
  end

  always_comb begin
    logic [RS_SIZE-1:0] avail;
    logic               found;
    int                 slot;
    avail      = ~(rs_busy | held_rs);
    found      = 1'b0;
    slot       = 0;
    free_rs    = 0;
    n_rob      = 0;
    n_lsq      = 0;
    n_rs       = 0;
    nx_rob_tag = '0;
    nx_lsq_id  = '0;
    nx_rs_id   = '0;
    nx_uses_rs = '0;
    nx_tag1    = '0;
    nx_tag2    = '0;
    nx_val1    = '0;
    nx_val2    = '0;
    for (int j = 0; j < RS_SIZE; j++)
      if (avail[j]) free_rs += 1;
    for (int i = 0; i < W; i++) begin
      if (in_valid[i]) begin
        slot = int'(rob_tail) + n_rob;
        if (slot >= ROB_SIZE) slot -= ROB_SIZE;
        nx_rob_tag[i*TW +: TW] = TW'(slot + 1);
        n_rob += 1;
        if (in_is_mem[i]) begin
          slot = int'(lsq_tail) + n_lsq;
          if (slot >= LSQ_SIZE) slot -= LSQ_SIZE;
          nx_lsq_id[i*LW +: LW] = LW'(slot + 1);
          n_lsq += 1;
        end
        if (!in_bypass_rs[i]) begin
          nx_uses_rs[i] = 1'b1;
          found         = 1'b0;
          for (int j = 0; j < RS_SIZE; j++)
            if (!found && avail[j]) begin
              nx_rs_id[i*SW +: SW] = SW'(j);
              avail[j]             = 1'b0;
              found                = 1'b1;
            end
          n_rs += 1;
        end
        {nx_tag1[i*TW +: TW], nx_val1[i*XLEN +: XLEN]} = cap(in_tag1[i*TW +: TW], in_val1[i*XLEN +: XLEN]);
        {nx_tag2[i*TW +: TW], nx_val2[i*XLEN +: XLEN]} = cap(in_tag2[i*TW +: TW], in_val2[i*XLEN +: XLEN]);
      end
    end
    slot = int'(rob_tail) + n_rob;
    if (slot >= ROB_SIZE) slot -= ROB_SIZE;
    rob_tail_nx = RIW'(slot);
    slot = int'(lsq_tail) + n_lsq;
    if (slot >= LSQ_SIZE) slot -= LSQ_SIZE;
    lsq_tail_nx = LIW'(slot);
  end

  // Free space comes from registered occupancy only; retires are credited next cycle.
  assign in_ready = (!(|out_valid) || out_ready) && !flush
                    && (n_rob <= ROB_SIZE - int'(rob_count))
                    && (n_lsq <= LSQ_SIZE - int'(lsq_count))
                    && (n_rs <= free_rs);
  assign accept   = in_valid[0] && in_ready;
  assign rob_full = (rob_count == TW'(ROB_SIZE));
  assign lsq_full = (lsq_count == LW'(LSQ_SIZE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rob_tail <= '0; lsq_tail <= '0; rob_count <= '0; lsq_count <= '0;
      out_valid <= '0; out_uses_rs <= '0; out_rob_tag <= '0; out_lsq_id <= '0;
      out_rs_id <= '0; out_tag1 <= '0; out_tag2 <= '0; out_val1 <= '0; out_val2 <= '0;
    end else if (flush) begin
      rob_tail <= '0; lsq_tail <= '0; rob_count <= '0; lsq_count <= '0;
      out_valid <= '0; out_uses_rs <= '0; out_rob_tag <= '0; out_lsq_id <= '0;
      out_rs_id <= '0; out_tag1 <= '0; out_tag2 <= '0; out_val1 <= '0; out_val2 <= '0;
    end else begin
      rob_count <= rob_count + (accept ? TW'(n_rob) : TW'(0)) - TW'(rob_retire);
      lsq_count <= lsq_count + (accept ? LW'(n_lsq) : LW'(0)) - LW'(lsq_retire);
      if (accept) begin
        rob_tail    <= rob_tail_nx;
        lsq_tail    <= lsq_tail_nx;
        out_valid   <= in_valid;
        out_uses_rs <= nx_uses_rs;
        out_rob_tag <= nx_rob_tag;
        out_lsq_id  <= nx_lsq_id;
        out_rs_id   <= nx_rs_id;
        out_tag1    <= nx_tag1;
        out_tag2    <= nx_tag2;
        out_val1    <= nx_val1;
        out_val2    <= nx_val2;
      end else if ((|out_valid) && out_ready) begin
        out_valid <= '0;
      end
`ifdef DISPATCH_CDB_SNOOP_EN
      else if (|out_valid) begin
        for (int i = 0; i < W; i++) begin
          {out_tag1[i*TW +: TW], out_val1[i*XLEN +: XLEN]} <= cap(out_tag1[i*TW +: TW], out_val1[i*XLEN +: XLEN]);
          {out_tag2[i*TW +: TW], out_val2[i*XLEN +: XLEN]} <= cap(out_tag2[i*TW +: TW], out_val2[i*XLEN +: XLEN]);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (TW'(rob_retire) <= rob_count);
      assert (LW'(lsq_retire) <= lsq_count);
    end
  end

endmodule
